// File: rtl/dispatch_stage.sv
// rtl/dispatch_stage.sv - issue-queue dispatch writer with pending buffer and credit tracking; optional same-cycle bypass under DISPATCH_BYPASS_EN
package dispatch_pkg;
    typedef logic [31:0] ISSUE_QUEUE_ELEMENT;
endpackage

module dispatch_stage
    import dispatch_pkg::*;
#(
    parameter int IQ_DEPTH   = 16,
    parameter int PUSH_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     dec_valid,
    input  ISSUE_QUEUE_ELEMENT [3:0] dec_data,
    input  logic [2:0]               dec_number,
    output logic                     dec_ready,
    input  logic [1:0]               iq_pop_number,
    output ISSUE_QUEUE_ELEMENT [3:0] iq_in_data,
    output logic [2:0]               iq_in_data_number,
    output logic [4:0]               credits,
    output logic [2:0]               pend_count
);
    localparam logic [4:0] DEPTH = 5'(IQ_DEPTH);
    localparam logic [2:0] PW    = 3'(PUSH_WIDTH);

    ISSUE_QUEUE_ELEMENT [3:0] pend;
    ISSUE_QUEUE_ELEMENT [3:0] pend_next;
    ISSUE_QUEUE_ELEMENT       cand [8];
    logic [2:0]               cred_cap;
    logic [2:0]               n_pend;
    logic [2:0]               n;
    logic [2:0]               pend_count_next;
    logic [3:0]               avail;
    logic [3:0]               total;
    logic                     accept;
    logic [5:0]               cred_sum;
    logic [4:0]               credits_next;

    // Push count: limited by entries on hand, credits and push width; a packet is taken only when the buffer fully drains
    always_comb begin
        cred_cap  = (credits > {2'b00, PW}) ? PW : credits[2:0];
        n_pend    = (pend_count > cred_cap) ? cred_cap : pend_count;
        dec_ready = !flush && (n_pend == pend_count);
        accept    = dec_valid && dec_ready;
        total     = {1'b0, pend_count} + (accept ? {1'b0, dec_number} : 4'd0);
`ifdef DISPATCH_BYPASS_EN
        avail     = total;
`else
        avail     = {1'b0, pend_count};
`endif
        if (flush) begin
            n = 3'd0;
        end else if (avail > {1'b0, cred_cap}) begin
            n = cred_cap;
        end else begin
            n = avail[2:0];
        end
        iq_in_data_number = n;
        pend_count_next   = 3'(total - {1'b0, n});
    end

    // Candidate stream in program order: buffered entries first, then the decode packet
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cand[3'(i)] = '0;
            if (i < int'(pend_count)) begin
                cand[3'(i)] = pend[2'(i)];
            end else if (i < int'(pend_count) + 4) begin
                cand[3'(i)] = dec_data[2'(i - int'(pend_count))];
            end
        end
    end

    // Push slots take the oldest n candidates; leftovers compact toward slot 0
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            iq_in_data[i] = (i < int'(n)) ? cand[3'(i)] : '0;
            pend_next[i]  = (i < int'(pend_count_next)) ? cand[3'(int'(n) + i)] : '0;
        end
    end

    // Credit update: pushes consume and pops return on the same edge, clamped at queue depth
    always_comb begin
        cred_sum     = {1'b0, credits} - {3'b000, n} + {4'b0000, iq_pop_number};
        credits_next = (cred_sum > {1'b0, DEPTH}) ? DEPTH : cred_sum[4:0];
    end

    // State register: reset and flush both empty the buffer and restore full credit
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pend       <= '0;
            pend_count <= 3'd0;
            credits    <= DEPTH;
        end else begin
            pend       <= pend_next;
            pend_count <= pend_count_next;
            credits    <= credits_next;
        end
    end

    assert property (@(posedge clk) disable iff (rst) dec_valid |-> (dec_number <= 3'd4));
    assert property (@(posedge clk) disable iff (rst || flush) (cred_sum <= {1'b0, DEPTH}));

endmodule

// File: tb/tb_dispatch_stage.sv
// tb/tb_dispatch_stage.sv - self-checking bench for dispatch_stage against a queue-based reference model
module tb_dispatch_stage;
    import dispatch_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     dec_valid;
    ISSUE_QUEUE_ELEMENT [3:0] dec_data;
    logic [2:0]               dec_number;
    logic                     dec_ready;
    logic [1:0]               iq_pop_number;
    ISSUE_QUEUE_ELEMENT [3:0] iq_in_data;
    logic [2:0]               iq_in_data_number;
    logic [4:0]               credits;
    logic [2:0]               pend_count;

    dispatch_stage #(.IQ_DEPTH(16), .PUSH_WIDTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .dec_valid         (dec_valid),
        .dec_data          (dec_data),
        .dec_number        (dec_number),
        .dec_ready         (dec_ready),
        .iq_pop_number     (iq_pop_number),
        .iq_in_data        (iq_in_data),
        .iq_in_data_number (iq_in_data_number),
        .credits           (credits),
        .pend_count        (pend_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    ISSUE_QUEUE_ELEMENT       pq[$];
    int                       m_cred;
    int                       tag = 0;
    ISSUE_QUEUE_ELEMENT [3:0] pkt;

    int                 exp_n;
    int                 exp_cred;
    int                 exp_pend;
    bit                 exp_ready;
    ISSUE_QUEUE_ELEMENT exp_data [4];

    logic [2:0]         obs_n;
    logic               obs_ready;
    logic [4:0]         obs_cred;
    logic [2:0]         obs_pend;
    ISSUE_QUEUE_ELEMENT obs_data [4];

    task automatic make_pkt(input int dn);
        for (int i = 0; i < 4; i++) begin
            if (i < dn) begin
                pkt[i] = {8'hD0, 24'(tag)};
                tag++;
            end else begin
                pkt[i] = $urandom();
            end
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        flush         = 1'b0;
        dec_valid     = 1'b0;
        dec_number    = 3'd0;
        dec_data      = '0;
        iq_pop_number = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pq.delete();
        m_cred = 16;
    endtask

    // One clock: model decides expected pushes, inputs driven, outputs captured mid-cycle, state captured after the edge
    task automatic cycle(input bit dv, input int dn, input int pop_req, input bit fl);
        ISSUE_QUEUE_ELEMENT seq[$];
        int  cap;
        int  n;
        int  pop;
        int  pop_max;
        bit  acc;
        cap       = (m_cred < 4) ? m_cred : 4;
        exp_ready = !fl && (pq.size() <= cap);
        acc       = dv && exp_ready;
        seq       = pq;
`ifdef DISPATCH_BYPASS_EN
        if (acc) begin
            for (int i = 0; i < dn; i++) seq.push_back(pkt[i]);
        end
`endif
        n     = fl ? 0 : ((seq.size() < cap) ? seq.size() : cap);
        exp_n = n;
        for (int i = 0; i < 4; i++) exp_data[i] = (i < n) ? seq[i] : '0;
        pop_max = 16 - (m_cred - n);
        pop     = (pop_req < pop_max) ? pop_req : pop_max;
        rst           = 1'b0;
        flush         = fl;
        dec_valid     = dv;
        dec_number    = 3'(dn);
        dec_data      = pkt;
        iq_pop_number = 2'(pop);
        @(negedge clk);
        obs_n     = iq_in_data_number;
        obs_ready = dec_ready;
        for (int i = 0; i < 4; i++) obs_data[i] = iq_in_data[i];
        if (fl) begin
            pq.delete();
            m_cred = 16;
        end else begin
            if (acc) begin
                for (int i = 0; i < dn; i++) pq.push_back(pkt[i]);
            end
            for (int i = 0; i < n; i++) void'(pq.pop_front());
            m_cred = m_cred - n + pop;
        end
        exp_cred = m_cred;
        exp_pend = pq.size();
        @(posedge clk);
        #1;
        obs_cred = credits;
        obs_pend = pend_count;
        dec_valid     = 1'b0;
        flush         = 1'b0;
        iq_pop_number = 2'd0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (pend_count !== 3'd0) begin failures++; $display("FAIL reset.pend_count got=%0d exp=0", pend_count); end
        checks++; if (credits !== 5'd16) begin failures++; $display("FAIL reset.credits got=%0d exp=16", credits); end
        checks++; if (iq_in_data_number !== 3'd0) begin failures++; $display("FAIL reset.iq_in_data_number got=%0d exp=0", iq_in_data_number); end
        checks++; if (iq_in_data !== '0) begin failures++; $display("FAIL reset.iq_in_data got=%h exp=0", iq_in_data); end
        checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset.dec_ready got=%b exp=1", dec_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_packet();
        int dv_t[2]  = '{1, 0};
        int dn_t[2]  = '{3, 0};
`ifdef DISPATCH_BYPASS_EN
        int push_step = 0;
`else
        int push_step = 1;
`endif
        do_reset();
        for (int s = 0; s < 2; s++) begin
            make_pkt(dn_t[s]);
            cycle(dv_t[s] != 0, dn_t[s], 0, 1'b0);
            checks++; if (obs_n !== 3'(exp_n)) begin failures++; $display("FAIL single.n step=%0d got=%0d exp=%0d", s, obs_n, exp_n); end
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL single.ready step=%0d got=%b exp=%b", s, obs_ready, exp_ready); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_data[i] !== exp_data[i]) begin failures++; $display("FAIL single.data step=%0d slot=%0d got=%h exp=%h", s, i, obs_data[i], exp_data[i]); end
            end
            checks++; if (obs_cred !== 5'(exp_cred)) begin failures++; $display("FAIL single.credits step=%0d got=%0d exp=%0d", s, obs_cred, exp_cred); end
            checks++; if (obs_pend !== 3'(exp_pend)) begin failures++; $display("FAIL single.pend step=%0d got=%0d exp=%0d", s, obs_pend, exp_pend); end
            if (s == push_step) begin
                checks++; if (obs_n !== 3'd3) begin failures++; $display("FAIL single.n3 got=%0d exp=3", obs_n); end
                checks++; if (obs_cred !== 5'd13) begin failures++; $display("FAIL single.cred13 got=%0d exp=13", obs_cred); end
                checks++; if (obs_data[3] !== '0) begin failures++; $display("FAIL single.slot3 got=%h exp=0", obs_data[3]); end
            end
        end
    endtask

    task automatic test_credit_stall();
        int dv_t[11]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int dn_t[11]  = '{4, 4, 4, 2, 4, 4, 4, 4, 0, 0, 0};
        int pop_t[11] = '{0, 0, 0, 0, 0, 0, 2, 0, 2, 2, 2};
        do_reset();
        for (int s = 0; s < 11; s++) begin
            make_pkt(dn_t[s]);
            cycle(dv_t[s] != 0, dn_t[s], pop_t[s], 1'b0);
            checks++; if (obs_n !== 3'(exp_n)) begin failures++; $display("FAIL stall.n step=%0d got=%0d exp=%0d", s, obs_n, exp_n); end
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL stall.ready step=%0d got=%b exp=%b", s, obs_ready, exp_ready); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_data[i] !== exp_data[i]) begin failures++; $display("FAIL stall.data step=%0d slot=%0d got=%h exp=%h", s, i, obs_data[i], exp_data[i]); end
            end
            checks++; if (obs_cred !== 5'(exp_cred)) begin failures++; $display("FAIL stall.credits step=%0d got=%0d exp=%0d", s, obs_cred, exp_cred); end
            checks++; if (obs_pend !== 3'(exp_pend)) begin failures++; $display("FAIL stall.pend step=%0d got=%0d exp=%0d", s, obs_pend, exp_pend); end
`ifndef DISPATCH_BYPASS_EN
            if (s == 5) begin
                checks++; if (obs_n !== 3'd2 || obs_ready !== 1'b0 || obs_cred !== 5'd0) begin failures++; $display("FAIL stall.partial n=%0d ready=%b credits=%0d exp n=2 ready=0 credits=0", obs_n, obs_ready, obs_cred); end
            end
            if (s == 6) begin
                checks++; if (obs_n !== 3'd0 || obs_ready !== 1'b0 || obs_cred !== 5'd2) begin failures++; $display("FAIL stall.zero_credit n=%0d ready=%b credits=%0d exp n=0 ready=0 credits=2", obs_n, obs_ready, obs_cred); end
            end
            if (s == 7) begin
                checks++; if (obs_n !== 3'd2 || obs_ready !== 1'b1) begin failures++; $display("FAIL stall.refill n=%0d ready=%b exp n=2 ready=1", obs_n, obs_ready); end
            end
            if (s == 9 || s == 10) begin
                checks++; if (obs_n !== 3'd2) begin failures++; $display("FAIL stall.pop_rate step=%0d n=%0d exp=2", s, obs_n); end
            end
`endif
        end
    endtask

    task automatic test_flush();
        int dv_t[6]  = '{1, 1, 1, 1, 1, 0};
        int dn_t[6]  = '{4, 4, 3, 3, 4, 0};
        int fl_t[6]  = '{0, 0, 0, 0, 1, 0};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            make_pkt(dn_t[s]);
            cycle(dv_t[s] != 0, dn_t[s], 0, fl_t[s] != 0);
            checks++; if (obs_n !== 3'(exp_n)) begin failures++; $display("FAIL flush.n step=%0d got=%0d exp=%0d", s, obs_n, exp_n); end
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL flush.ready step=%0d got=%b exp=%b", s, obs_ready, exp_ready); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_data[i] !== exp_data[i]) begin failures++; $display("FAIL flush.data step=%0d slot=%0d got=%h exp=%h", s, i, obs_data[i], exp_data[i]); end
            end
            checks++; if (obs_cred !== 5'(exp_cred)) begin failures++; $display("FAIL flush.credits step=%0d got=%0d exp=%0d", s, obs_cred, exp_cred); end
            checks++; if (obs_pend !== 3'(exp_pend)) begin failures++; $display("FAIL flush.pend step=%0d got=%0d exp=%0d", s, obs_pend, exp_pend); end
`ifndef DISPATCH_BYPASS_EN
            if (s == 3) begin
                checks++; if (obs_cred !== 5'd5 || obs_pend !== 3'd3) begin failures++; $display("FAIL flush.setup credits=%0d pend=%0d exp credits=5 pend=3", obs_cred, obs_pend); end
            end
`endif
            if (s == 4) begin
                checks++; if (obs_n !== 3'd0 || obs_ready !== 1'b0) begin failures++; $display("FAIL flush.cycle n=%0d ready=%b exp n=0 ready=0", obs_n, obs_ready); end
                checks++; if (obs_cred !== 5'd16 || obs_pend !== 3'd0) begin failures++; $display("FAIL flush.after credits=%0d pend=%0d exp credits=16 pend=0", obs_cred, obs_pend); end
            end
        end
    endtask

`ifdef DISPATCH_BYPASS_EN
    task automatic test_bypass();
        int dv_t[7]  = '{1, 1, 1, 1, 1, 0, 0};
        int dn_t[7]  = '{4, 4, 4, 1, 4, 0, 0};
        int pop_t[7] = '{0, 0, 0, 0, 0, 2, 0};
        do_reset();
        for (int s = 0; s < 7; s++) begin
            make_pkt(dn_t[s]);
            cycle(dv_t[s] != 0, dn_t[s], pop_t[s], 1'b0);
            checks++; if (obs_n !== 3'(exp_n)) begin failures++; $display("FAIL bypass.n step=%0d got=%0d exp=%0d", s, obs_n, exp_n); end
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL bypass.ready step=%0d got=%b exp=%b", s, obs_ready, exp_ready); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_data[i] !== exp_data[i]) begin failures++; $display("FAIL bypass.data step=%0d slot=%0d got=%h exp=%h", s, i, obs_data[i], exp_data[i]); end
            end
            checks++; if (obs_cred !== 5'(exp_cred)) begin failures++; $display("FAIL bypass.credits step=%0d got=%0d exp=%0d", s, obs_cred, exp_cred); end
            checks++; if (obs_pend !== 3'(exp_pend)) begin failures++; $display("FAIL bypass.pend step=%0d got=%0d exp=%0d", s, obs_pend, exp_pend); end
            if (s == 4) begin
                checks++; if (obs_n !== 3'd3 || obs_ready !== 1'b1 || obs_pend !== 3'd1) begin failures++; $display("FAIL bypass.same_cycle n=%0d ready=%b pend=%0d exp n=3 ready=1 pend=1", obs_n, obs_ready, obs_pend); end
            end
            if (s == 6) begin
                checks++; if (obs_n !== 3'd1) begin failures++; $display("FAIL bypass.leftover n=%0d exp=1", obs_n); end
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
`ifdef DISPATCH_BYPASS_EN
        int first_full = 0;
`else
        int first_full = 1;
`endif
        do_reset();
        for (int s = 0; s < 6; s++) begin
            make_pkt(4);
            cycle(1'b1, 4, 2, 1'b0);
            checks++; if (obs_n !== 3'(exp_n)) begin failures++; $display("FAIL b2b.n step=%0d got=%0d exp=%0d", s, obs_n, exp_n); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_data[i] !== exp_data[i]) begin failures++; $display("FAIL b2b.data step=%0d slot=%0d got=%h exp=%h", s, i, obs_data[i], exp_data[i]); end
            end
            checks++; if (obs_cred !== 5'(exp_cred)) begin failures++; $display("FAIL b2b.credits step=%0d got=%0d exp=%0d", s, obs_cred, exp_cred); end
            checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL b2b.ready step=%0d got=%b exp=1", s, obs_ready); end
            if (s >= first_full) begin
                checks++; if (obs_n !== 3'd4) begin failures++; $display("FAIL b2b.full step=%0d got=%0d exp=4", s, obs_n); end
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 49) == 0) begin
                make_pkt(4);
                rst           = 1'b1;
                flush         = 1'($urandom_range(0, 1));
                dec_valid     = 1'b1;
                dec_number    = 3'd4;
                dec_data      = pkt;
                iq_pop_number = 2'd0;
                @(posedge clk);
                #1;
                rst   = 1'b0;
                flush = 1'b0;
                dec_valid = 1'b0;
                pq.delete();
                m_cred = 16;
                checks++; if (pend_count !== 3'd0 || credits !== 5'd16) begin failures++; $display("FAIL rand.reset step=%0d pend=%0d credits=%0d exp pend=0 credits=16", s, pend_count, credits); end
            end else begin
                int dn;
                dn = $urandom_range(0, 4);
                make_pkt(dn);
                cycle($urandom_range(0, 3) != 0, dn, $urandom_range(0, 2), $urandom_range(0, 39) == 0);
                checks++; if (obs_n !== 3'(exp_n)) begin failures++; $display("FAIL rand.n step=%0d got=%0d exp=%0d", s, obs_n, exp_n); end
                checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rand.ready step=%0d got=%b exp=%b", s, obs_ready, exp_ready); end
                for (int i = 0; i < 4; i++) begin
                    checks++; if (obs_data[i] !== exp_data[i]) begin failures++; $display("FAIL rand.data step=%0d slot=%0d got=%h exp=%h", s, i, obs_data[i], exp_data[i]); end
                end
                checks++; if (obs_cred !== 5'(exp_cred)) begin failures++; $display("FAIL rand.credits step=%0d got=%0d exp=%0d", s, obs_cred, exp_cred); end
                checks++; if (obs_pend !== 3'(exp_pend)) begin failures++; $display("FAIL rand.pend step=%0d got=%0d exp=%0d", s, obs_pend, exp_pend); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_credit_stall();
        test_flush();
`ifdef DISPATCH_BYPASS_EN
        test_bypass();
`endif
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
